lifo_buffer: RTL and testbench

//  Synchronous last-in-first-out stack of LIFO_SIZE entries, DATA_W bits each.

---
 rtl/lifo_pkg.sv | 32 +++
 rtl/lifo_mem.sv | 41 ++++
 rtl/lifo_buffer.sv | 139 +++++++++++++
 tb/tb_lifo_buffer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lifo_pkg
// Description : Shared definitions for the LIFO stack: default geometry,
//               occupancy-counter width helper and the per-cycle op decode.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Contents:
//   DEF_LIFO_SIZE  default number of entries
//   DEF_DATA_W     default word width
//   cnt_width()    width of a counter able to hold 0..size inclusive
//   lifo_op_e      NOP / PUSH / POP / SWAP
// ============================================================================
package lifo_pkg;

    localparam int DEF_LIFO_SIZE = 8;
    localparam int DEF_DATA_W    = 8;

    // Occupancy runs from 0 to size inclusive, hence size+1 states.
    function automatic int cnt_width(input int size);
        return $clog2(size + 1);
    endfunction

    typedef enum logic [1:0] {
        NOP  = 2'd0,
        PUSH = 2'd1,
        POP  = 2'd2,
        SWAP = 2'd3
    } lifo_op_e;

endpackage
`default_nettype wire

// File: rtl/lifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : lifo_mem
// Description : DEPTH x DATA_W register array backing the LIFO stack.
//               One synchronous write port, one combinational read port.
//               Contents are intentionally not reset.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk     in   rising-edge clock
//   wr_en   in   write strobe
//   wr_addr in   write address
//   wr_data in   write data
//   rd_addr in   read address
//   rd_data out  combinational read data at rd_addr
// ============================================================================
module lifo_mem #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/lifo_buffer.sv
`default_nettype none
// ============================================================================
// Module      : lifo_buffer
// Description : Synchronous last-in-first-out stack of LIFO_SIZE entries of
//               DATA_W bits. Occupancy is tracked by a saturating stack
//               pointer; status flags and the popped word are registered.
//               Optional feature macro: LIFO_ERR_FLAGS_EN adds the
//               overflow/underflow pulse outputs.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous reset, active-low
//   write      in   push request (data_in sampled on the edge)
//   read       in   pop request
//   data_in    in   word to push
//   data_out   out  last popped word (held until the next successful pop)
//   data_valid out  one-cycle pulse when data_out was updated
//   full       out  occupancy == LIFO_SIZE
//   empty      out  occupancy == 0
//   count      out  current occupancy
//   overflow   out  pulse after a rejected push   (LIFO_ERR_FLAGS_EN only)
//   underflow  out  pulse after a rejected pop    (LIFO_ERR_FLAGS_EN only)
// ============================================================================
module lifo_buffer
    import lifo_pkg::*;
#(
    parameter int LIFO_SIZE = DEF_LIFO_SIZE,
    parameter int DATA_W    = DEF_DATA_W
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                write,
    input  logic                                read,
    input  logic [DATA_W-1:0]                   data_in,
    output logic [DATA_W-1:0]                   data_out,
    output logic                                data_valid,
    output logic                                full,
    output logic                                empty,
    output logic [cnt_width(LIFO_SIZE)-1:0]     count
`ifdef LIFO_ERR_FLAGS_EN
    ,
    output logic                                overflow,
    output logic                                underflow
`endif
);

    localparam int CNT_W  = cnt_width(LIFO_SIZE);
    localparam int ADDR_W = $clog2(LIFO_SIZE);
    localparam logic [CNT_W-1:0] SIZE_CNT = CNT_W'(LIFO_SIZE);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    lifo_op_e          op;
    logic [CNT_W-1:0]  count_nxt;
    logic [ADDR_W-1:0] top_addr;
    logic [ADDR_W-1:0] push_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;
    logic [DATA_W-1:0] top_data;

    // Op decode. A simultaneous push/pop on an empty stack has nothing to
    // return, so it degrades to a plain push. SWAP is allowed when full
    // because it does not change occupancy.
    always_comb begin
        op = NOP;
        if (write && read) begin
            op = empty ? PUSH : SWAP;
        end else if (write && !full) begin
            op = PUSH;
        end else if (read && !empty) begin
            op = POP;
        end
    end

    always_comb begin
        count_nxt = count;
        case (op)
            PUSH:    count_nxt = count + ONE_CNT;
            POP:     count_nxt = count - ONE_CNT;
            default: count_nxt = count;
        endcase
    end

    // count points one past the top entry; top_addr is only meaningful when
    // the stack is non-empty, which the decode guarantees for POP/SWAP.
    assign top_addr  = ADDR_W'(count - ONE_CNT);
    assign push_addr = ADDR_W'(count);
    assign wr_en     = (op == PUSH) || (op == SWAP);
    assign wr_addr   = (op == SWAP) ? top_addr : push_addr;

    lifo_mem #(
        .DEPTH  (LIFO_SIZE),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (data_in),
        .rd_addr (top_addr),
        .rd_data (top_data)
    );

    // full/empty are registered from the next count so they move on the
    // same edge as count itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count      <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            count      <= count_nxt;
            full       <= (count_nxt == SIZE_CNT);
            empty      <= (count_nxt == '0);
            data_valid <= (op == POP) || (op == SWAP);
            if ((op == POP) || (op == SWAP)) begin
                data_out <= top_data;
            end
        end
    end

`ifdef LIFO_ERR_FLAGS_EN
    // A pop paired with a push is never rejected: on an empty stack it
    // becomes a push, otherwise a swap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= write && !read && full;
            underflow <= read && !write && empty;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_lifo_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lifo_buffer
// Description : Self-checking bench for lifo_buffer (LIFO_SIZE=8, DATA_W=8)
//               using a queue-based reference stack.
// Revision    : 1.0  initial release
// ============================================================================
module tb_lifo_buffer;

    localparam int SIZE = 8;
    localparam int DW   = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          write;
    logic          read;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          full;
    logic          empty;
    logic [3:0]    count;
`ifdef LIFO_ERR_FLAGS_EN
    logic          overflow;
    logic          underflow;
`endif

    always #5 clk = ~clk;

    lifo_buffer #(
        .LIFO_SIZE (SIZE),
        .DATA_W    (DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .write      (write),
        .read       (read),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .full       (full),
        .empty      (empty),
        .count      (count)
`ifdef LIFO_ERR_FLAGS_EN
        ,
        .overflow   (overflow),
        .underflow  (underflow)
`endif
    );

    // Reference model: a plain queue whose back is the top of stack.
    logic [DW-1:0] stk [$];
    logic [DW-1:0] m_out;
    logic          m_valid;
    logic          m_of;
    logic          m_uf;

    int tests = 0;
    int fails = 0;

    task automatic model_reset();
        stk.delete();
        m_out   = '0;
        m_valid = 1'b0;
        m_of    = 1'b0;
        m_uf    = 1'b0;
    endtask

    // Drive one request, let the DUT take the edge, advance the model,
    // and return 1 time unit after the edge with inputs idled.
    task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d);
        write   = w;
        read    = r;
        data_in = d;
        @(posedge clk);
        m_valid = 1'b0;
        m_of    = 1'b0;
        m_uf    = 1'b0;
        if (w && r) begin
            if (stk.size() == 0) begin
                stk.push_back(d);
            end else begin
                m_out = stk[stk.size()-1];
                stk[stk.size()-1] = d;
                m_valid = 1'b1;
            end
        end else if (w) begin
            if (stk.size() < SIZE) stk.push_back(d);
            else m_of = 1'b1;
        end else if (r) begin
            if (stk.size() > 0) begin
                m_out   = stk.pop_back();
                m_valid = 1'b1;
            end else begin
                m_uf = 1'b1;
            end
        end
        #1;
        write = 1'b0;
        read  = 1'b0;
    endtask

    task automatic test_reset();
        tests++; if (count !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", count); end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b expected 1", empty); end
        tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b expected 0", full); end
        tests++; if (data_out !== 8'h00) begin fails++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
        tests++; if (data_valid !== 1'b0) begin fails++; $display("FAIL reset_data_valid: got %b expected 0", data_valid); end
    endtask

    task automatic test_push_pop();
        logic [DW-1:0] pv [4] = '{8'hFF, 8'h00, 8'hF0, 8'h0F};
        logic [DW-1:0] ev [4] = '{8'h0F, 8'hF0, 8'h00, 8'hFF};
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, pv[i]);
        tests++; if (count !== 4'd4) begin fails++; $display("FAIL pp_count: got %0d expected 4", count); end
        tests++; if (empty !== 1'b0) begin fails++; $display("FAIL pp_empty: got %b expected 0", empty); end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            tests++; if (data_out !== ev[i]) begin fails++; $display("FAIL pp_pop%0d_data: got %h expected %h", i, data_out, ev[i]); end
            tests++; if (data_valid !== 1'b1) begin fails++; $display("FAIL pp_pop%0d_valid: got %b expected 1", i, data_valid); end
        end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL pp_empty_after: got %b expected 1", empty); end
    endtask

    task automatic test_underflow();
        cycle(1'b0, 1'b1, 8'h00);
        tests++; if (data_out !== 8'hFF) begin fails++; $display("FAIL uf_data: got %h expected FF", data_out); end
        tests++; if (data_valid !== 1'b0) begin fails++; $display("FAIL uf_valid: got %b expected 0", data_valid); end
        tests++; if (count !== 4'd0) begin fails++; $display("FAIL uf_count: got %0d expected 0", count); end
`ifdef LIFO_ERR_FLAGS_EN
        tests++; if (underflow !== 1'b1) begin fails++; $display("FAIL uf_flag: got %b expected 1", underflow); end
        cycle(1'b0, 1'b0, 8'h00);
        tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL uf_flag_clear: got %b expected 0", underflow); end
`endif
    endtask

    task automatic test_swap();
        logic [DW-1:0] pv [7] = '{8'hFF, 8'h00, 8'hF0, 8'h0F, 8'h55, 8'h6C, 8'h10};
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, pv[i]);
        tests++; if (count !== 4'd7) begin fails++; $display("FAIL sw_count_pre: got %0d expected 7", count); end
        cycle(1'b1, 1'b1, 8'h01);
        tests++; if (data_out !== 8'h10) begin fails++; $display("FAIL sw_data: got %h expected 10", data_out); end
        tests++; if (data_valid !== 1'b1) begin fails++; $display("FAIL sw_valid: got %b expected 1", data_valid); end
        tests++; if (count !== 4'd7) begin fails++; $display("FAIL sw_count: got %0d expected 7", count); end
        // Confirm the new top, then restore it.
        cycle(1'b0, 1'b1, 8'h00);
        tests++; if (data_out !== 8'h01) begin fails++; $display("FAIL sw_top: got %h expected 01", data_out); end
        cycle(1'b1, 1'b0, 8'h01);
        tests++; if (count !== 4'd7) begin fails++; $display("FAIL sw_count_restore: got %0d expected 7", count); end
    endtask

    task automatic test_full();
        cycle(1'b1, 1'b0, 8'h81);
        tests++; if (count !== 4'd8) begin fails++; $display("FAIL fu_count: got %0d expected 8", count); end
        tests++; if (full !== 1'b1) begin fails++; $display("FAIL fu_full: got %b expected 1", full); end
        cycle(1'b0, 1'b1, 8'h00);
        tests++; if (data_out !== 8'h81) begin fails++; $display("FAIL fu_pop_data: got %h expected 81", data_out); end
        tests++; if (full !== 1'b0) begin fails++; $display("FAIL fu_full_clear: got %b expected 0", full); end
        cycle(1'b1, 1'b0, 8'h81);
        cycle(1'b1, 1'b0, 8'h80);
        tests++; if (count !== 4'd8) begin fails++; $display("FAIL fu_reject_count: got %0d expected 8", count); end
        tests++; if (full !== 1'b1) begin fails++; $display("FAIL fu_reject_full: got %b expected 1", full); end
`ifdef LIFO_ERR_FLAGS_EN
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL fu_overflow: got %b expected 1", overflow); end
`endif
    endtask

    task automatic test_swap_full();
        cycle(1'b1, 1'b1, 8'hAA);
        tests++; if (data_out !== 8'h81) begin fails++; $display("FAIL sf_data: got %h expected 81", data_out); end
        tests++; if (data_valid !== 1'b1) begin fails++; $display("FAIL sf_valid: got %b expected 1", data_valid); end
        tests++; if (count !== 4'd8) begin fails++; $display("FAIL sf_count: got %0d expected 8", count); end
        cycle(1'b0, 1'b1, 8'h00);
        tests++; if (data_out !== 8'hAA) begin fails++; $display("FAIL sf_pop_new: got %h expected AA", data_out); end
        cycle(1'b0, 1'b1, 8'h00);
        tests++; if (data_out !== 8'h01) begin fails++; $display("FAIL sf_pop_below: got %h expected 01", data_out); end
    endtask

    task automatic test_async_reset();
        cycle(1'b1, 1'b0, 8'h3C);
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b1, 1'b0, 8'h5A);
        // Mid-cycle: request in flight, reset asserted between edges.
        write   = 1'b1;
        data_in = 8'hC3;
        #2;
        reset = 1'b0;
        #1;
        tests++; if (count !== 4'd0) begin fails++; $display("FAIL ar_count: got %0d expected 0", count); end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL ar_empty: got %b expected 1", empty); end
        tests++; if (full !== 1'b0) begin fails++; $display("FAIL ar_full: got %b expected 0", full); end
        tests++; if (data_out !== 8'h00) begin fails++; $display("FAIL ar_data_out: got %h expected 00", data_out); end
        tests++; if (data_valid !== 1'b0) begin fails++; $display("FAIL ar_valid: got %b expected 0", data_valid); end
        write = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        int wpct;
        int rpct;
        logic w;
        logic r;
        for (int i = 0; i < 600; i++) begin
            // Phases bias toward filling, then draining, then mixed traffic.
            if (i < 200)      begin wpct = 75; rpct = 30; end
            else if (i < 400) begin wpct = 25; rpct = 75; end
            else              begin wpct = 50; rpct = 50; end
            w = ($urandom_range(0, 99) < wpct);
            r = ($urandom_range(0, 99) < rpct);
            cycle(w, r, 8'($urandom));
            tests++; if (count !== 4'(stk.size())) begin fails++; $display("FAIL rnd%0d_count: got %0d expected %0d", i, count, stk.size()); end
            tests++; if (empty !== (stk.size() == 0)) begin fails++; $display("FAIL rnd%0d_empty: got %b expected %b", i, empty, stk.size() == 0); end
            tests++; if (full !== (stk.size() == SIZE)) begin fails++; $display("FAIL rnd%0d_full: got %b expected %b", i, full, stk.size() == SIZE); end
            tests++; if (data_valid !== m_valid) begin fails++; $display("FAIL rnd%0d_valid: got %b expected %b", i, data_valid, m_valid); end
            tests++; if (data_out !== m_out) begin fails++; $display("FAIL rnd%0d_data: got %h expected %h", i, data_out, m_out); end
`ifdef LIFO_ERR_FLAGS_EN
            tests++; if (overflow !== m_of) begin fails++; $display("FAIL rnd%0d_overflow: got %b expected %b", i, overflow, m_of); end
            tests++; if (underflow !== m_uf) begin fails++; $display("FAIL rnd%0d_underflow: got %b expected %b", i, underflow, m_uf); end
`endif
        end
    endtask

    initial begin
        reset   = 1'b0;
        write   = 1'b0;
        read    = 1'b0;
        data_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        test_reset();
        test_push_pop();
        test_underflow();
        test_swap();
        test_full();
        test_swap_full();
        test_async_reset();
        test_reset();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
